// File: rtl/sm_regdump_uart_pkg.sv
// rtl/sm_regdump_uart_pkg.sv - dump FSM states, line format constants and hex helper; SM_REGDUMP_INDEX_EN selects indexed lines
package sm_regdump_uart_pkg;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_ADDR,
    RD_CAPT,
    RD_SEND,
    RD_WAITC,
    RD_NEXT,
    RD_FIN
  } rdState_t;

`ifdef SM_REGDUMP_INDEX_EN
  // "II:" prefix, 8 hex digits, LF
  localparam int RD_LINE_LEN = 12;
  localparam int RD_HEX_BASE = 3;
`else
  // 8 hex digits, LF
  localparam int RD_LINE_LEN = 9;
  localparam int RD_HEX_BASE = 0;
`endif

  localparam logic [7:0] RD_CHAR_LF    = 8'h0A;
  localparam logic [7:0] RD_CHAR_COLON = 8'h3A;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// rtl/sm_uart_tx.sv - 8N1 UART transmitter, BAUD_DIV clocks per bit
module sm_uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] LAST_TICK = 16'(BAUD_DIV - 1);

  logic        active;
  logic [15:0] baudCnt;
  logic [3:0]  bitCnt;
  logic [7:0]  shiftReg;

  // ready also rises in the final cycle of the stop bit so a registered
  // valid from the caller lands exactly when the line goes idle
  assign ready = !active || (bitCnt == 4'd9 && baudCnt == LAST_TICK);

  // frame sequencer: bit 0 is the start bit, 1..8 data LSB first, 9 stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      tx       <= 1'b1;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else if (!active) begin
      if (valid) begin
        active   <= 1'b1;
        tx       <= 1'b0;
        baudCnt  <= '0;
        bitCnt   <= '0;
        shiftReg <= data;
      end
    end else if (baudCnt == LAST_TICK) begin
      baudCnt <= '0;
      if (bitCnt == 4'd9) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bitCnt   <= bitCnt + 4'd1;
        tx       <= shiftReg[0];
        // ones shifted in become the stop bit after the eighth data bit
        shiftReg <= {1'b1, shiftReg[7:1]};
      end
    end else begin
      baudCnt <= baudCnt + 16'd1;
    end
  end

endmodule

// File: rtl/sm_regdump_uart.sv
// rtl/sm_regdump_uart.sv - walks regAddr 0..31, prints each word as hex lines over UART; SM_REGDUMP_INDEX_EN adds an "II:" prefix
module sm_regdump_uart
  import sm_regdump_uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST_CHAR = 4'(RD_LINE_LEN - 1);

  rdState_t    state;
  logic [4:0]  index;
  logic [31:0] shadow;
  logic [3:0]  charPos;
  logic        txValid;
  logic        txReady;
  logic [7:0]  txData;
  logic [2:0]  digitSel;

  // character mux: picks the glyph for the current line position
  always_comb begin
    digitSel = 3'(charPos - 4'(RD_HEX_BASE));
    txData   = hexChar(4'(shadow >> (5'd28 - {digitSel, 2'b00})));
`ifdef SM_REGDUMP_INDEX_EN
    if (charPos == 4'd0)           txData = hexChar({3'b000, index[4]});
    else if (charPos == 4'd1)      txData = hexChar(index[3:0]);
    else if (charPos == 4'd2)      txData = RD_CHAR_COLON;
    else if (charPos == LAST_CHAR) txData = RD_CHAR_LF;
`else
    if (charPos == LAST_CHAR) txData = RD_CHAR_LF;
`endif
  end

  // dump sequencer: address, capture into shadow, stream the line, next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      index   <= '0;
      regAddr <= '0;
      shadow  <= '0;
      charPos <= '0;
      txValid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      txValid <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (start) begin
            index <= '0;
            busy  <= 1'b1;
            state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          regAddr <= index;
          state   <= RD_CAPT;
        end
        RD_CAPT: begin
          // regData has had one cycle to settle on the new address
          shadow  <= regData;
          charPos <= '0;
          txValid <= 1'b1;
          state   <= RD_SEND;
        end
        RD_SEND: begin
          // txValid is high this cycle; the transmitter takes txData now
          state <= RD_WAITC;
        end
        RD_WAITC: begin
          if (txReady) begin
            if (charPos == LAST_CHAR) begin
              state <= RD_NEXT;
            end else begin
              charPos <= charPos + 4'd1;
              txValid <= 1'b1;
              state   <= RD_SEND;
            end
          end
        end
        RD_NEXT: begin
          if (index == 5'd31) begin
            regAddr <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= RD_FIN;
          end else begin
            index <= index + 5'd1;
            state <= RD_ADDR;
          end
        end
        RD_FIN: begin
          state <= RD_IDLE;
        end
        default: begin
          state <= RD_IDLE;
        end
      endcase
    end
  end

  sm_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) uTx (
    .clk  (clk),
    .rst  (rst),
    .data (txData),
    .valid(txValid),
    .ready(txReady),
    .tx   (tx)
  );

endmodule

// File: tb/tb_sm_regdump_uart.sv
// tb/tb_sm_regdump_uart.sv - directed/randomized bench with UART decoder and string-level reference lines
module tb_sm_regdump_uart;

  localparam int BD = 4;
`ifdef SM_REGDUMP_INDEX_EN
  localparam int LEN = 12;
`else
  localparam int LEN = 9;
`endif
  localparam int EXP_BUSY = 32 * (3 + LEN * (10 * BD + 1));
  localparam int DONE_LIMIT = 20000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] modelBase;
  logic        overrideOn;
  logic [127:0] hexTab;
  logic [7:0]  rxQ[$];
  int          epoch;
  int          errors = 0;
  int          checks = 0;
  int          doneCnt = 0;
  int          busyCnt = 0;

  assign regData = overrideOn ? 32'h12345678 : (modelBase ^ {27'd0, regAddr});

  sm_regdump_uart #(
    .BAUD_DIV(BD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .regAddr(regAddr),
    .regData(regData),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse/level monitor
  always @(negedge clk) begin
    if (done === 1'b1) doneCnt++;
    if (busy === 1'b1) busyCnt++;
  end

  // UART decoder sampling each bit near its middle
  always begin : uartRx
    int ep;
    logic [7:0] ch;
    logic stopOk;
    @(negedge clk);
    if (tx === 1'b0) begin
      ep = epoch;
      repeat (BD + 1) @(negedge clk);
      ch[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        ch[i] = tx;
      end
      repeat (BD) @(negedge clk);
      stopOk = (tx === 1'b1);
      if (stopOk && ep == epoch) rxQ.push_back(ch);
    end
  end

  // swap regData right after the capture of register 5
  initial begin : overrideCtl
    overrideOn = 1'b0;
    do @(negedge clk); while (regAddr !== 5'd5);
    @(posedge clk);
    #1 overrideOn = 1'b1;
    do @(negedge clk); while (regAddr === 5'd5);
    overrideOn = 1'b0;
  end

  function automatic logic [7:0] hexOf(input int n);
    return hexTab[8*(15-n) +: 8];
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitDone(input bit pokeFin);
    int n = 0;
    while (done !== 1'b1 && n < DONE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 96'(done), 96'(1));
    check("busy_low_with_done", 96'(busy), 96'(0));
    if (pokeFin) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitRx(input int target);
    int n = 0;
    while (rxQ.size() < target && n < DONE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("rx_progress", 96'(rxQ.size() >= target), 96'(1));
  endtask

  task automatic checkDump(input int rb, input logic [31:0] base, input string tag);
    logic [95:0] got;
    logic [95:0] exp;
    logic [31:0] w;
    int p;
    check({tag, "_char_count"}, 96'(rxQ.size() - rb), 96'(32 * LEN));
    for (int i = 0; i < 32; i++) begin
      got = '0;
      exp = '0;
      w = base ^ 32'(i);
      for (int c = 0; c < LEN; c++) begin
        p = rb + i * LEN + c;
        got = {got[87:0], (p < rxQ.size()) ? rxQ[p] : 8'h00};
      end
`ifdef SM_REGDUMP_INDEX_EN
      exp = {exp[87:0], hexOf(i / 16)};
      exp = {exp[87:0], hexOf(i % 16)};
      exp = {exp[87:0], 8'h3A};
`endif
      for (int d = 0; d < 8; d++) exp = {exp[87:0], hexOf(int'((w >> (28 - 4 * d)) & 32'hF))};
      exp = {exp[87:0], 8'h0A};
      check($sformatf("%s_line%0d", tag, i), got, exp);
    end
  endtask

  initial begin : main
    int rb, b0, d0, n;
    logic [41:0] samp;
    logic [41:0] expFrame;
    logic [7:0] firstCh;
    bit sawBusy;

    hexTab    = "0123456789ABCDEF";
    start     = 1'b0;
    rst       = 1'b1;
    epoch     = 0;
    modelBase = 32'hDEAD0000;

    repeat (3) @(negedge clk);
    check("reset_tx", 96'(tx), 96'(1));
    check("reset_busy", 96'(busy), 96'(0));
    check("reset_done", 96'(done), 96'(0));
    check("reset_regAddr", 96'(regAddr), 96'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // dump 1: latency, first frame waveform, shadow isolation, FIN start drop
`ifdef SM_REGDUMP_INDEX_EN
    firstCh = 8'h30;
`else
    firstCh = hexOf(int'(modelBase >> 28));
`endif
    for (int j = 0; j < 42; j++) begin
      if (j < 40) expFrame[j] = (j / BD == 0) ? 1'b0 : (j / BD == 9) ? 1'b1 : firstCh[j / BD - 1];
      else expFrame[j] = (j == 40);
    end
    rb = rxQ.size(); b0 = busyCnt; d0 = doneCnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 96'(busy), 96'(1));
    n = 1;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("start_latency", 96'(n), 96'(4));
    samp[0] = tx;
    for (int j = 1; j < 42; j++) begin
      @(negedge clk);
      samp[j] = tx;
    end
    check("first_frame", 96'(samp), 96'(expFrame));
    waitDone(1'b1);
    sawBusy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) sawBusy = 1'b1;
    end
    check("fin_start_dropped", 96'(sawBusy), 96'(0));
    check("d1_done_pulses", 96'(doneCnt - d0), 96'(1));
    check("d1_busy_cycles", 96'(busyCnt - b0), 96'(EXP_BUSY));
    check("d1_regAddr_home", 96'(regAddr), 96'(0));
    checkDump(rb, 32'hDEAD0000, "d1");

    // dump 2: second start at char 50 must be ignored
    rb = rxQ.size(); b0 = busyCnt; d0 = doneCnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitRx(rb + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(1'b0);
    repeat (5) @(negedge clk);
    check("d2_done_pulses", 96'(doneCnt - d0), 96'(1));
    check("d2_busy_cycles", 96'(busyCnt - b0), 96'(EXP_BUSY));
    checkDump(rb, 32'hDEAD0000, "d2");

    // reset during char 10, bit 3
    rb = rxQ.size(); d0 = doneCnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitRx(rb + 10);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("char10_start_seen", 96'(tx), 96'(0));
    repeat (3 * BD + 2) @(negedge clk);
    rst = 1'b1;
    epoch++;
    #1;
    check("async_rst_tx", 96'(tx), 96'(1));
    check("async_rst_busy", 96'(busy), 96'(0));
    check("async_rst_regAddr", 96'(regAddr), 96'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("no_done_after_abort", 96'(doneCnt - d0), 96'(0));

    // dump 3: random register contents after the abort
    modelBase = $urandom;
    rb = rxQ.size(); b0 = busyCnt; d0 = doneCnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(1'b0);
    repeat (5) @(negedge clk);
    check("d3_done_pulses", 96'(doneCnt - d0), 96'(1));
    check("d3_busy_cycles", 96'(busyCnt - b0), 96'(EXP_BUSY));
    checkDump(rb, modelBase, "d3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
